divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 62 ++++++
 tb/tb_divider.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/divider.sv
// ============================================================================
// Module   : divider
// Purpose  : Divides CLK by DIV into a registered CLK_OUT; optional one-cycle
//            TICK per output period, compiled in when DIVIDER_TICK_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module divider #(
    parameter int DIV   = 40000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    output logic CLK_OUT
`ifdef DIVIDER_TICK_EN
    ,
    output logic TICK
`endif
);

    // Ratios below 2 collapse to 2; counter is widened if CNT_W is too small.
    localparam int D_EFF = (DIV < 2) ? 2 : DIV;
    localparam int W     = (CNT_W < $clog2(D_EFF)) ? $clog2(D_EFF) : CNT_W;
    localparam logic [W-1:0] LAST = W'(D_EFF - 1);
    localparam logic [W-1:0] HALF = W'(D_EFF / 2);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt + W'(1);
        if (cnt == LAST) begin
            cnt_next = '0;
        end
    end

    // CLK_OUT follows the value the counter takes on this edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            CLK_OUT <= 1'b0;
        end else if (EN) begin
            cnt     <= cnt_next;
            CLK_OUT <= (cnt_next >= HALF);
        end
    end

`ifdef DIVIDER_TICK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            TICK <= 1'b0;
        end else begin
            TICK <= EN && (cnt_next == LAST);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// Testbench for divider: three ratios (4, 5, 1->2) with random enables,
// checked against an edge-count reference model.
`default_nettype none

module tb_divider;

    logic clk = 1'b0;
    logic rst_n;
    logic en4, en5, en1;
    logic out4, out5, out1;
`ifdef DIVIDER_TICK_EN
    logic tick4, tick5, tick1;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: enabled edges since reset, per instance.
    int n4, n5, n1;

    always #10 clk = ~clk;

    divider #(.DIV(4)) u4 (
        .CLK(clk), .RST_N(rst_n), .EN(en4), .CLK_OUT(out4)
`ifdef DIVIDER_TICK_EN
        , .TICK(tick4)
`endif
    );

    divider #(.DIV(5)) u5 (
        .CLK(clk), .RST_N(rst_n), .EN(en5), .CLK_OUT(out5)
`ifdef DIVIDER_TICK_EN
        , .TICK(tick5)
`endif
    );

    divider #(.DIV(1)) u1 (
        .CLK(clk), .RST_N(rst_n), .EN(en1), .CLK_OUT(out1)
`ifdef DIVIDER_TICK_EN
        , .TICK(tick1)
`endif
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_out(input int n, input int d);
        return ((n % d) >= (d / 2));
    endfunction

    function automatic logic exp_tick(input int n, input int d, input logic en);
        return en && ((n % d) == d - 1);
    endfunction

    // One rising edge, advance the model, then compare away from the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            n4 = 0; n5 = 0; n1 = 0;
        end else begin
            if (en4) n4++;
            if (en5) n5++;
            if (en1) n1++;
        end
        check("out4", out4, exp_out(n4, 4));
        check("out5", out5, exp_out(n5, 5));
        check("out1", out1, exp_out(n1, 2));
`ifdef DIVIDER_TICK_EN
        check("tick4", tick4, exp_tick(n4, 4, en4 && rst_n));
        check("tick5", tick5, exp_tick(n5, 5, en5 && rst_n));
        check("tick1", tick1, exp_tick(n1, 2, en1 && rst_n));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        en4 = 1'b1; en5 = 1'b1; en1 = 1'b1;
        n4 = 0; n5 = 0; n1 = 0;

        // Reset state, with EN high to show reset wins
        #1;
        check("rst_out4", out4, 1'b0);
        check("rst_out5", out5, 1'b0);
        repeat (2) cycle();

        // Free-running: 0,1,1,0,... for DIV=4 and 2-low/3-high for DIV=5
        rst_n = 1'b1;
        repeat (12) cycle();

        // Random enables
        for (int i = 0; i < 80; i++) begin
            en4 = ($urandom % 4) != 0;
            en5 = ($urandom % 4) != 0;
            en1 = ($urandom % 3) != 0;
            cycle();
        end

        // Drop EN for 3 cycles while DIV=4 output is high
        en4 = 1'b1; en5 = 1'b1; en1 = 1'b1;
        for (int k = 0; k < 8 && out4 !== 1'b1; k++) cycle();
        check("wait_hi4_a", out4, 1'b1);
        en4 = 1'b0;
        repeat (3) cycle();
        check("hold_hi4", out4, 1'b1);
        en4 = 1'b1;
        repeat (6) cycle();

        // Asynchronous reset pulse between edges while output is high
        for (int k = 0; k < 8 && out4 !== 1'b1; k++) cycle();
        check("wait_hi4_b", out4, 1'b1);
        #4;
        rst_n = 1'b0;
        #1;
        check("async_out4", out4, 1'b0);
        check("async_out5", out5, 1'b0);
        check("async_out1", out1, 1'b0);
`ifdef DIVIDER_TICK_EN
        check("async_tick4", tick4, 1'b0);
`endif
        n4 = 0; n5 = 0; n1 = 0;
        #3;
        rst_n = 1'b1;
        repeat (10) cycle();

        // More random enables with occasional synchronous-time resets
        for (int i = 0; i < 120; i++) begin
            en4 = ($urandom % 5) != 0;
            en5 = ($urandom % 5) != 0;
            en1 = ($urandom % 2) != 0;
            rst_n = ($urandom % 40) != 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
